// File: rtl/zorro_cycle_master.sv
// Zorro II/III bus-cycle master: one queued command becomes one timed slave cycle
// (ADDR -> STROBE -> DATA -> RECOVER -> RESP) on the z_sample_clk grid.
module zorro_cycle_master #(
  parameter int MODE        = 0,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int SETUP_CYC   = 14,
  parameter int STROBE_CYC  = 20,
  parameter int DOE_CYC     = 8,
  parameter int HOLD_CYC    = 1,
  parameter int USE_ACK     = 0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                z_sample_clk,
  input  logic                znRST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  input  logic                z_ack,
  output logic                znAS,
  output logic                znFCS,
  output logic                zREAD,
  output logic [DATA_W/8-1:0] z_nds,
  output logic                zDOE,
  output logic [ADDR_W-1:0]   zA,
  output logic [DATA_W-1:0]   zD_out,
  output logic                zD_oe,
  input  logic [DATA_W-1:0]   zD_in
);

  localparam int NB      = DATA_W / 8;
  localparam int M1      = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int M2      = (DOE_CYC > HOLD_CYC) ? DOE_CYC : HOLD_CYC;
  localparam int M3      = (TIMEOUT_CYC > M1) ? TIMEOUT_CYC : M1;
  localparam int MAX_CYC = (M3 > M2) ? M3 : M2;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  generate
    if (SETUP_CYC < 1 || STROBE_CYC < 1 || DOE_CYC < 1 || HOLD_CYC < 1 || TIMEOUT_CYC < 1 ||
        !((MODE == 0 && DATA_W == 16) || (MODE == 1 && DATA_W == 32))) begin : g_bad_param
      $error("zorro_cycle_master: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_STROBE  = 3'd2,
    ST_DATA    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [NB-1:0]     be_q, be_d;
  logic [ADDR_W-1:0] za_q, za_d;
  logic [DATA_W-1:0] zd_out_q, zd_out_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              as_n_q, as_n_d;
  logic              zread_q, zread_d;
  logic [NB-1:0]     z_nds_q, z_nds_d;
  logic              zdoe_q, zdoe_d;
  logic              zd_oe_q, zd_oe_d;

  logic last_setup_s, last_doe_s, last_hold_s, strobe_min_s, strobe_done_s, strobe_tmo_s;

  assign last_setup_s  = (cnt_q == CNT_W'(SETUP_CYC - 1));
  assign last_doe_s    = (cnt_q == CNT_W'(DOE_CYC - 1));
  assign last_hold_s   = (cnt_q == CNT_W'(HOLD_CYC - 1));
  assign strobe_min_s  = (cnt_q >= CNT_W'(STROBE_CYC - 1));
  assign strobe_done_s = (USE_ACK == 0) ? strobe_min_s : (strobe_min_s && z_ack);
  assign strobe_tmo_s  = (USE_ACK != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next state, latched command and all registered bus/response outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    wr_d     = wr_q;
    be_d     = be_q;
    za_d     = za_q;
    zd_out_d = zd_out_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cmd_valid && cmd_ready_q) begin
          state_d  = ST_ADDR;
          wr_d     = cmd_write;
          be_d     = cmd_be;
          za_d     = cmd_addr;
          zd_out_d = cmd_wdata;
          rdata_d  = '0;
          err_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (last_setup_s) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_STROBE: begin
        // A completing handshake wins over a timeout landing on the same clock.
        if (strobe_done_s) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else if (strobe_tmo_s) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_DATA: begin
        if (last_doe_s) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
          rdata_d = wr_q ? '0 : zD_in;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RECOVER: begin
        if (last_hold_s) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    cmd_ready_d = (state_d == ST_IDLE);
    as_n_d      = !(state_d inside {ST_ADDR, ST_STROBE, ST_DATA});
    zread_d     = !(wr_d && (state_d inside {ST_ADDR, ST_STROBE, ST_DATA, ST_RECOVER}));
    z_nds_d     = (state_d == ST_STROBE) ? ~be_d : {NB{1'b1}};
    zdoe_d      = (state_d == ST_DATA);
    zd_oe_d     = wr_d && (state_d inside {ST_ADDR, ST_STROBE});
    rsp_valid_d = (state_d == ST_RESP);
    rsp_rdata_d = (state_d == ST_RESP) ? rdata_d : '0;
    rsp_err_d   = (state_d == ST_RESP) ? err_d : 1'b0;
  end

  // State and output registers; reset is synchronous to z_sample_clk.
  always_ff @(posedge z_sample_clk) begin
    if (!znRST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      be_q        <= '0;
      za_q        <= '0;
      zd_out_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      as_n_q      <= 1'b1;
      zread_q     <= 1'b1;
      z_nds_q     <= {NB{1'b1}};
      zdoe_q      <= 1'b0;
      zd_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      za_q        <= za_d;
      zd_out_q    <= zd_out_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      as_n_q      <= as_n_d;
      zread_q     <= zread_d;
      z_nds_q     <= z_nds_d;
      zdoe_q      <= zdoe_d;
      zd_oe_q     <= zd_oe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign znAS      = (MODE == 0) ? as_n_q : 1'b1;
  assign znFCS     = (MODE == 1) ? as_n_q : 1'b1;
  assign zREAD     = zread_q;
  assign z_nds     = z_nds_q;
  assign zDOE      = zdoe_q;
  assign zA        = za_q;
  assign zD_out    = zd_out_q;
  assign zD_oe     = zd_oe_q;

endmodule
